// File: rtl/cache_define.sv
// Shared types for the LLC replacement controller: op codes, FSM states, PLRU sizing.
package cache_define;

    typedef enum logic [1:0] {
        PLRU_HIT    = 2'd0,
        PLRU_VICTIM = 2'd1,
        PLRU_INVAL  = 2'd2
    } plru_op_e;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_LOOKUP = 2'd2,
        ST_RESP   = 2'd3
    } plru_state_e;

    localparam int PLRU_WAYS = 8;
    localparam int PLRU_BITS = PLRU_WAYS - 1;

endpackage

// File: rtl/plru_tree_next.sv
// Combinational tree-PLRU next-state: selects the victim way and rewrites the path for HIT/VICTIM/INVAL.
// Zero latency; no flow control. Reserved op leaves the word untouched and returns way 0.
module plru_tree_next
    import cache_define::*;
#(
    parameter int WAYS  = 8,
    parameter int WAY_W = $clog2(WAYS)
) (
    input  logic [WAYS-2:0]  word_i,
    input  logic [1:0]       op_i,
    input  logic [WAY_W-1:0] way_i,
    input  logic [WAYS-1:0]  vmask_i,
    output logic [WAYS-2:0]  word_o,
    output logic [WAY_W-1:0] way_o
);

    logic [WAY_W-1:0] sel;
    logic [WAY_W:0]   node;
    logic             inv;
    logic             known;

    always_comb begin
        word_o = word_i;
        way_o  = '0;
        sel    = way_i;
        node   = '0;
        inv    = (op_i == PLRU_INVAL);
        known  = (op_i == PLRU_HIT) || (op_i == PLRU_VICTIM) || (op_i == PLRU_INVAL);

        if (op_i == PLRU_VICTIM) begin
            if (!(&vmask_i)) begin
                // Descending scan so the lowest invalid way wins.
                for (int i = WAYS - 1; i >= 0; i--) begin
                    if (!vmask_i[i]) sel = WAY_W'(i);
                end
            end else begin
                for (int l = WAY_W - 1; l >= 0; l--) begin
                    sel[l] = ~word_i[node[WAY_W-1:0]];
                    node   = (node << 1) + {{WAY_W{1'b0}}, 1'b1} + {{WAY_W{1'b0}}, sel[l]};
                end
            end
        end

        if (known) begin
            node = '0;
            for (int l = WAY_W - 1; l >= 0; l--) begin
                word_o[node[WAY_W-1:0]] = sel[l] ^ inv;
                node = (node << 1) + {{WAY_W{1'b0}}, 1'b1} + {{WAY_W{1'b0}}, sel[l]};
            end
            way_o = sel;
        end
    end

endmodule

// File: rtl/plru_repl_ctrl.sv
// LLC replacement controller: per-set tree-PLRU storage, one RMW request at a time; PLRU_STATS_EN adds op counters.
// Latency: accept -> LOOKUP -> RESP, rsp_valid one cycle after the LOOKUP cycle.
// Backpressure: req_ready only in IDLE; RESP holds outputs stable until rsp_ready.
module plru_repl_ctrl
    import cache_define::*;
#(
    parameter int WAYS     = 8,
    parameter int NUM_SETS = 16,
    parameter int WAY_W    = $clog2(WAYS),
    parameter int SET_W    = $clog2(NUM_SETS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [SET_W-1:0] req_set,
    input  logic [WAY_W-1:0] req_way,
    input  logic [WAYS-1:0]  req_vmask,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WAY_W-1:0] rsp_way,
`ifdef PLRU_STATS_EN
    output logic [31:0]      stat_hit,
    output logic [31:0]      stat_victim,
    output logic [31:0]      stat_inval,
`endif
    output logic             rsp_err
);

    localparam int PB = WAYS - 1;

    plru_state_e      state_q;
    logic [SET_W-1:0] cnt_q;
    logic [1:0]       op_q;
    logic [SET_W-1:0] set_q;
    logic [WAY_W-1:0] way_q;
    logic [WAYS-1:0]  vmask_q;
    logic             req_ready_q;
    logic             rsp_valid_q;
    logic [WAY_W-1:0] rsp_way_q;
    logic             rsp_err_q;

    // Deliberately unreset: the INIT sweep is what clears it.
    logic [PB-1:0]    plru_q [NUM_SETS];

    logic [PB-1:0]    word_d;
    logic [WAY_W-1:0] way_d;
    logic             wr_en;
    logic [SET_W-1:0] wr_idx;
    logic [PB-1:0]    wr_dat;

    plru_tree_next #(.WAYS(WAYS), .WAY_W(WAY_W)) u_tree (
        .word_i  (plru_q[set_q]),
        .op_i    (op_q),
        .way_i   (way_q),
        .vmask_i (vmask_q),
        .word_o  (word_d),
        .way_o   (way_d)
    );

    always_comb begin
        wr_en  = (state_q == ST_INIT) || (state_q == ST_LOOKUP);
        wr_idx = (state_q == ST_INIT) ? cnt_q : set_q;
        wr_dat = (state_q == ST_INIT) ? '0 : word_d;
    end

    always_ff @(posedge clk) begin
        if (wr_en) plru_q[wr_idx] <= wr_dat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            op_q        <= '0;
            set_q       <= '0;
            way_q       <= '0;
            vmask_q     <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_way_q   <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == SET_W'(NUM_SETS - 1)) begin
                        state_q     <= ST_IDLE;
                        req_ready_q <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (req_valid && req_ready_q) begin
                        op_q        <= req_op;
                        set_q       <= req_set;
                        way_q       <= req_way;
                        vmask_q     <= req_vmask;
                        req_ready_q <= 1'b0;
                        state_q     <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    rsp_way_q   <= way_d;
                    rsp_err_q   <= (op_q == 2'd3);
                    rsp_valid_q <= 1'b1;
                    state_q     <= ST_RESP;
                end
                default: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
            endcase
        end
    end

`ifdef PLRU_STATS_EN
    logic [31:0] stat_hit_q, stat_victim_q, stat_inval_q;
    logic        rsp_hs;

    assign rsp_hs = (state_q == ST_RESP) && rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_hit_q    <= '0;
            stat_victim_q <= '0;
            stat_inval_q  <= '0;
        end else if (rsp_hs) begin
            if (op_q == PLRU_HIT && !(&stat_hit_q))       stat_hit_q    <= stat_hit_q + 1'b1;
            if (op_q == PLRU_VICTIM && !(&stat_victim_q)) stat_victim_q <= stat_victim_q + 1'b1;
            if (op_q == PLRU_INVAL && !(&stat_inval_q))   stat_inval_q  <= stat_inval_q + 1'b1;
        end
    end

    assign stat_hit    = stat_hit_q;
    assign stat_victim = stat_victim_q;
    assign stat_inval  = stat_inval_q;
`endif

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_way   = rsp_way_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_plru_repl_ctrl.sv
// Directed bench for plru_repl_ctrl: expected responses queued at issue, compared when rsp_valid rises.
module tb_plru_repl_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [1:0] req_op = 2'd0;
    logic [3:0] req_set = 4'd0;
    logic [2:0] req_way = 3'd0;
    logic [7:0] req_vmask = 8'd0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [2:0] rsp_way;
    logic       rsp_err;
`ifdef PLRU_STATS_EN
    logic [31:0] stat_hit, stat_victim, stat_inval;
`endif

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_q [$];

    always #5 clk = ~clk;

    plru_repl_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_set   (req_set),
        .req_way   (req_way),
        .req_vmask (req_vmask),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_way   (rsp_way),
`ifdef PLRU_STATS_EN
        .stat_hit    (stat_hit),
        .stat_victim (stat_victim),
        .stat_inval  (stat_inval),
`endif
        .rsp_err   (rsp_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [1:0] op, input logic [3:0] set, input logic [2:0] way,
                        input logic [7:0] vm, input logic [2:0] ew, input logic ee, input int hold);
        int cnt;
        logic [3:0] exp;
        exp_q.push_back({ee, ew});
        req_op = op; req_set = set; req_way = way; req_vmask = vm; req_valid = 1'b1;
        cnt = 0;
        while (!req_ready && cnt < 200) begin @(negedge clk); cnt++; end
        check("accept_timeout", 32'(cnt < 200), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        check("lookup_rsp_valid", 32'(rsp_valid), 32'd0);
        check("lookup_req_ready", 32'(req_ready), 32'd0);
        cnt = 0;
        while (!rsp_valid && cnt < 50) begin @(negedge clk); cnt++; end
        check("rsp_latency", 32'(cnt), 32'd1);
        exp = exp_q.pop_front();
        check("rsp_way", 32'(rsp_way), 32'(exp[2:0]));
        check("rsp_err", 32'(rsp_err), 32'(exp[3]));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("stall_valid", 32'(rsp_valid), 32'd1);
            check("stall_way", 32'(rsp_way), 32'(exp[2:0]));
            check("stall_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("post_hs_valid", 32'(rsp_valid), 32'd0);
        check("post_hs_ready", 32'(req_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        #12;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_way", 32'(rsp_way), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        while (!req_ready && cnt < 100) begin @(posedge clk); cnt++; #1; end
        check("init_cycles", 32'(cnt), 32'd16);
        @(negedge clk);

        send(2'd1, 4'd3, 3'd0, 8'hFF, 3'd7, 1'b0, 0);
        send(2'd1, 4'd3, 3'd0, 8'hFF, 3'd3, 1'b0, 0);
        send(2'd0, 4'd5, 3'd5, 8'hFF, 3'd5, 1'b0, 0);
        send(2'd2, 4'd5, 3'd5, 8'hFF, 3'd5, 1'b0, 0);
        send(2'd1, 4'd5, 3'd0, 8'hFF, 3'd5, 1'b0, 0);
        send(2'd1, 4'd3, 3'd0, 8'b1111_1011, 3'd2, 1'b0, 0);
        send(2'd1, 4'd3, 3'd0, 8'hFF, 3'd5, 1'b0, 0);
        send(2'd1, 4'd0, 3'd0, 8'hFF, 3'd7, 1'b0, 0);
        send(2'd1, 4'd15, 3'd0, 8'hFF, 3'd7, 1'b0, 5);
        send(2'd3, 4'd5, 3'd6, 8'hFF, 3'd0, 1'b1, 0);
        send(2'd1, 4'd5, 3'd0, 8'hFF, 3'd3, 1'b0, 0);
        send(2'd1, 4'd6, 3'd0, 8'b0000_0000, 3'd0, 1'b0, 0);

        // Reset while a response is pending on set 5.
        req_op = 2'd1; req_set = 4'd5; req_vmask = 8'hFF; req_valid = 1'b1;
        cnt = 0;
        while (!req_ready && cnt < 200) begin @(negedge clk); cnt++; end
        @(negedge clk);
        req_valid = 1'b0;
        cnt = 0;
        while (!rsp_valid && cnt < 50) begin @(negedge clk); cnt++; end
        check("pre_rst_valid", 32'(rsp_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(rsp_valid), 32'd0);
        check("async_rst_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        while (!req_ready && cnt < 100) begin @(posedge clk); cnt++; #1; end
        check("reinit_cycles", 32'(cnt), 32'd16);
        @(negedge clk);
        send(2'd1, 4'd5, 3'd0, 8'hFF, 3'd7, 1'b0, 0);
        send(2'd1, 4'd3, 3'd0, 8'hFF, 3'd7, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
